// File: rtl/tap_ir_dr_datapath.sv
// JTAG IR/DR datapath downstream of the TAP controller.
// Holds the IR shift/update pair and the BYPASS, IDCODE and USER data
// registers. It also drives the TDO mux. The block follows the
// controller's state code and never decodes TMS itself.
module tap_ir_dr_datapath #(
    parameter int unsigned           IR_WIDTH   = 4,
    parameter logic [31:0]           IDCODE_VAL = 32'h1234_5093,
    parameter int unsigned           USER_WIDTH = 8,
    parameter logic [IR_WIDTH-1:0]   OP_IDCODE  = 4'b0001,
    parameter logic [IR_WIDTH-1:0]   OP_USER    = 4'b0010
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic [3:0]            state,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  TDO_EN,
    output logic [IR_WIDTH-1:0]   IR,
    input  logic [USER_WIDTH-1:0] USER_IN,
    output logic [USER_WIDTH-1:0] USER_OUT,
    output logic                  USER_UPD
);

    localparam logic [3:0] ST_TLR        = 4'd0;
    localparam logic [3:0] ST_CAPTURE_DR = 4'd3;
    localparam logic [3:0] ST_SHIFT_DR   = 4'd4;
    localparam logic [3:0] ST_UPDATE_DR  = 4'd8;
    localparam logic [3:0] ST_CAPTURE_IR = 4'd10;
    localparam logic [3:0] ST_SHIFT_IR   = 4'd11;
    localparam logic [3:0] ST_UPDATE_IR  = 4'd15;

    // Low two bits 01 are what the standard requires in Capture_IR.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    logic [IR_WIDTH-1:0]   ir_sr;
    logic                  bypass_sr;
    logic [31:0]           id_sr;
    logic [USER_WIDTH-1:0] user_sr;

    logic sel_id;
    logic sel_user;
    logic sel_bypass;

    // DR select decodes the latched instruction, so it stays stable while a new IR shifts in.
    always_comb begin
        sel_id     = (IR == OP_IDCODE);
        sel_user   = (IR == OP_USER);
        sel_bypass = !(sel_id || sel_user);
    end

    // IR shift stage: capture the fixed pattern, then shift toward TDO.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_sr <= '0;
        end else begin
            case (state)
                ST_CAPTURE_IR: ir_sr <= IR_CAPTURE;
                ST_SHIFT_IR:   ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
                default:       ir_sr <= ir_sr;
            endcase
        end
    end

    // Instruction latch: Test_Logic_Reset forces IDCODE and Update_IR loads the shift stage.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            IR <= OP_IDCODE;
        end else begin
            case (state)
                ST_TLR:       IR <= OP_IDCODE;
                ST_UPDATE_IR: IR <= ir_sr;
                default:      IR <= IR;
            endcase
        end
    end

    // BYPASS: a single stage that captures 0.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            bypass_sr <= 1'b0;
        end else if (sel_bypass) begin
            case (state)
                ST_CAPTURE_DR: bypass_sr <= 1'b0;
                ST_SHIFT_DR:   bypass_sr <= TDI;
                default:       bypass_sr <= bypass_sr;
            endcase
        end
    end

    // IDCODE: captures the device ID and shifts it out LSB first.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            id_sr <= '0;
        end else if (sel_id) begin
            case (state)
                ST_CAPTURE_DR: id_sr <= IDCODE_VAL;
                ST_SHIFT_DR:   id_sr <= {TDI, id_sr[31:1]};
                default:       id_sr <= id_sr;
            endcase
        end
    end

    // USER scan register: captures USER_IN in parallel and shifts serially.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            user_sr <= '0;
        end else if (sel_user) begin
            case (state)
                ST_CAPTURE_DR: user_sr <= USER_IN;
                ST_SHIFT_DR:   user_sr <= {TDI, user_sr[USER_WIDTH-1:1]};
                default:       user_sr <= user_sr;
            endcase
        end
    end

    // USER update latch and its one-cycle strobe. A reset mid-scan clears USER_OUT instead of exposing partial data.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            USER_OUT <= '0;
            USER_UPD <= 1'b0;
        end else begin
            USER_UPD <= 1'b0;
            if (state == ST_UPDATE_DR && sel_user) begin
                USER_OUT <= user_sr;
                USER_UPD <= 1'b1;
            end
        end
    end

    // TDO mux and enable are combinational from state so the first bit is valid in the first Shift cycle.
    always_comb begin
        TDO_EN = (state == ST_SHIFT_DR) || (state == ST_SHIFT_IR);
        TDO    = 1'b0;
        if (state == ST_SHIFT_IR) begin
            TDO = ir_sr[0];
        end else if (state == ST_SHIFT_DR) begin
            if (sel_id)        TDO = id_sr[0];
            else if (sel_user) TDO = user_sr[0];
            else               TDO = bypass_sr;
        end
    end

endmodule

// File: tb/tb_tap_ir_dr_datapath.sv
// Testbench for tap_ir_dr_datapath. It runs directed scans with literal
// expectations, then a randomized state walk. Every output is compared each
// cycle against a model that holds the registers as bit queues (index 0 sits
// next to TDO).
module tb_tap_ir_dr_datapath;

    localparam logic [3:0]  OP_IDCODE = 4'b0001;
    localparam logic [3:0]  OP_USER   = 4'b0010;
    localparam logic [31:0] IDCODE    = 32'h1234_5093;

    typedef bit bq_t[$];

    logic       TCK = 1'b0;
    logic       TRST = 1'b1;
    logic [3:0] state = 4'd0;
    logic       TDI = 1'b0;
    logic       TDO;
    logic       TDO_EN;
    logic [3:0] IR;
    logic [7:0] USER_IN = 8'h00;
    logic [7:0] USER_OUT;
    logic       USER_UPD;

    tap_ir_dr_datapath dut (
        .TCK      (TCK),
        .TRST     (TRST),
        .state    (state),
        .TDI      (TDI),
        .TDO      (TDO),
        .TDO_EN   (TDO_EN),
        .IR       (IR),
        .USER_IN  (USER_IN),
        .USER_OUT (USER_OUT),
        .USER_UPD (USER_UPD)
    );

    always #5 TCK = ~TCK;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    bq_t  ir_q, by_q, id_q, us_q;
    int   m_ir;
    int   m_uout;
    bit   m_upd;
    bit   m_valid = 0;

    function automatic bq_t mk_q(input int w, input logic [31:0] v);
        bq_t q;
        q = {};
        for (int i = 0; i < w; i++) q.push_back(v[i]);
        return q;
    endfunction

    function automatic bq_t sh_q(input bq_t q, input bit b);
        bq_t r;
        r = q;
        r.delete(0);
        r.push_back(b);
        return r;
    endfunction

    function automatic int q_val(input bq_t q);
        int v;
        v = 0;
        foreach (q[i]) if (q[i]) v = v | (1 << i);
        return v;
    endfunction

    // 0 bypass, 1 idcode, 2 user
    function automatic int m_sel();
        if (m_ir == int'(OP_IDCODE)) return 1;
        if (m_ir == int'(OP_USER))   return 2;
        return 0;
    endfunction

    always @(posedge TCK) begin
        int sel;
        sel   = m_sel();
        m_upd = 0;
        if (TRST) begin
            m_valid = 1;
            m_ir    = int'(OP_IDCODE);
            ir_q    = mk_q(4, 0);
            by_q    = mk_q(1, 0);
            id_q    = mk_q(32, 0);
            us_q    = mk_q(8, 0);
            m_uout  = 0;
        end else if (m_valid) begin
            case (state)
                4'd0:  m_ir = int'(OP_IDCODE);
                4'd10: ir_q = mk_q(4, 32'd1);
                4'd11: ir_q = sh_q(ir_q, TDI);
                4'd15: m_ir = q_val(ir_q);
                4'd3: begin
                    if (sel == 1)      id_q = mk_q(32, IDCODE);
                    else if (sel == 2) us_q = mk_q(8, {24'd0, USER_IN});
                    else               by_q = mk_q(1, 0);
                end
                4'd4: begin
                    if (sel == 1)      id_q = sh_q(id_q, TDI);
                    else if (sel == 2) us_q = sh_q(us_q, TDI);
                    else               by_q = sh_q(by_q, TDI);
                end
                4'd8: begin
                    if (sel == 2) begin
                        m_uout = q_val(us_q);
                        m_upd  = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic bit m_tdo();
        int sel;
        sel = m_sel();
        if (state == 4'd11) return ir_q[0];
        if (state == 4'd4) begin
            if (sel == 1) return id_q[0];
            if (sel == 2) return us_q[0];
            return by_q[0];
        end
        return 0;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge TCK) begin
        #1;
        if (m_valid) begin
            check("tdo_en", {31'd0, TDO_EN}, {31'd0, (state == 4'd4 || state == 4'd11)});
            check("tdo", {31'd0, TDO}, {31'd0, m_tdo()});
            check("ir", {28'd0, IR}, m_ir);
            check("user_out", {24'd0, USER_OUT}, m_uout);
            check("user_upd", {31'd0, USER_UPD}, {31'd0, m_upd});
        end
    end

    // ---------------- directed stimulus ----------------
    logic s_tdo;
    logic s_en;
    int   upd_cnt = 0;

    task automatic step(input logic [3:0] st, input logic tdi, input logic rst);
        @(negedge TCK);
        TRST  = rst;
        state = st;
        TDI   = tdi;
        #1;
        s_tdo = TDO;
        s_en  = TDO_EN;
        if (USER_UPD === 1'b1) upd_cnt++;
    endtask

    task automatic load_ir(input logic [3:0] v);
        step(4'd10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'd11, v[i], 1'b0);
        step(4'd15, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  irv;
        logic [7:0]  pv;
        logic [7:0]  tdi8;
        int          en_cnt;
        int          r;

        // Reset, then IDCODE readout
        step(4'd0, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0);
        en_cnt = 0;
        rd = '0;
        for (int k = 0; k < 32; k++) begin
            step(4'd4, 1'b0, 1'b0);
            rd[k] = s_tdo;
            if (s_en === 1'b1) en_cnt++;
        end
        check("idcode_read", rd, 32'h1234_5093);
        check("idcode_en_cycles", en_cnt, 32);
        step(4'd5, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);

        // IR capture pattern, then load USER opcode
        step(4'd10, 1'b0, 1'b0);
        irv = 4'b0010;
        rd = '0;
        for (int k = 0; k < 4; k++) begin
            step(4'd11, irv[k], 1'b0);
            rd[k] = s_tdo;
        end
        check("ir_capture", rd, 32'h1);
        step(4'd15, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        check("ir_loaded", {28'd0, IR}, 32'h2);

        // BYPASS with all-ones and 0111 opcodes
        for (int pass = 0; pass < 2; pass++) begin
            load_ir(pass == 0 ? 4'b1111 : 4'b0111);
            step(4'd3, 1'b0, 1'b0);
            irv = 4'b1101;
            rd = '0;
            for (int k = 0; k < 4; k++) begin
                step(4'd4, irv[k], 1'b0);
                rd[k] = s_tdo;
            end
            check("bypass_tdo", rd, 32'b1010);
            step(4'd5, 1'b0, 1'b0);
            step(4'd8, 1'b0, 1'b0);
        end

        // Pause/resume inside a USER scan
        load_ir(OP_USER);
        USER_IN = 8'h5A;
        pv = 8'h96;
        step(4'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(4'd4, pv[k], 1'b0);
        step(4'd5, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(4'd6, 1'b1, 1'b0);
        step(4'd7, 1'b0, 1'b0);
        for (int k = 3; k < 8; k++) step(4'd4, pv[k], 1'b0);
        step(4'd5, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        check("pause_resume_out", {24'd0, USER_OUT}, 32'h96);

        // USER round trip
        USER_IN = 8'hA5;
        tdi8 = 8'h3C;
        step(4'd3, 1'b0, 1'b0);
        rd = '0;
        for (int k = 0; k < 8; k++) begin
            step(4'd4, tdi8[k], 1'b0);
            rd[k] = s_tdo;
        end
        check("user_tdo", rd, 32'hA5);
        upd_cnt = 0;
        step(4'd5, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        check("user_upd_high", {31'd0, USER_UPD}, 32'h1);
        check("user_out", {24'd0, USER_OUT}, 32'h3C);
        step(4'd1, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        check("user_upd_pulses", upd_cnt, 1);

        // Zero-shift update: USER_OUT takes USER_IN directly
        USER_IN = 8'hC3;
        step(4'd3, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        check("zero_shift_out", {24'd0, USER_OUT}, 32'hC3);

        // Reload 3C, then reset during the 4th shift
        step(4'd3, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(4'd4, tdi8[k], 1'b0);
        step(4'd5, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        check("pre_reset_out", {24'd0, USER_OUT}, 32'h3C);
        step(4'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(4'd4, 1'b1, 1'b0);
        upd_cnt = 0;
        step(4'd4, 1'b1, 1'b1);
        step(4'd1, 1'b0, 1'b0);
        check("reset_user_out", {24'd0, USER_OUT}, 32'h0);
        check("reset_ir", {28'd0, IR}, 32'h1);
        step(4'd5, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        check("reset_no_upd", upd_cnt, 0);

        // Randomized state walk weighted toward the active states
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] st;
            r = $urandom_range(0, 99);
            if (r < 30)      st = 4'd4;
            else if (r < 45) st = 4'd11;
            else if (r < 55) st = 4'd3;
            else if (r < 62) st = 4'd10;
            else if (r < 68) st = 4'd8;
            else if (r < 73) st = 4'd15;
            else if (r < 75) st = 4'd0;
            else             st = 4'($urandom_range(0, 15));
            USER_IN = 8'($urandom);
            step(st, 1'($urandom), ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        step(4'd1, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
